mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory of the multicycle CPU between two requesters: the CPU (instruction fetch and data access via its IorD path) and a DMA/program-loader port.
- Sequences each access as issue, wait MEM_LAT, capture, ack.
- Drives a stall to the CPU control FSM while its access is pending.
- Sits between the CPU memory interface and the memory macro.

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between CPU and DMA; define ARB_RR_EN for round-robin instead of fixed priority with starvation guard
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          arb_busy,
  output logic          arb_owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t        state_q, state_d;
  logic [3:0]    lat_q, lat_d, wait_q, wait_d;
  logic          last_q, last_d, own_q, own_d, we_q, we_d, gnt_dma;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic          mem_en_q, mem_we_q, cpu_ack_q, dma_ack_q, busy_q;
`ifdef ARB_RR_EN
  assign gnt_dma = dma_req & (~cpu_req | ~last_q);
`else
  assign gnt_dma = dma_req & (~cpu_req | (wait_q == 4'(MAX_WAIT)));
`endif
  // Sequence grant, issue, latency wait and ack; latch the winner's fields and capture read data
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    wait_d      = wait_q;
    last_d      = last_q;
    own_d       = own_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      IDLE: if (cpu_req | dma_req) begin
        state_d = ISSUE;
        own_d   = gnt_dma;
        last_d  = gnt_dma;
        we_d    = gnt_dma ? dma_we : cpu_we;
        addr_d  = gnt_dma ? dma_addr : cpu_addr;
        wdata_d = gnt_dma ? dma_wdata : cpu_wdata;
`ifndef ARB_RR_EN
        wait_d  = gnt_dma ? 4'd0 : (dma_req && wait_q != 4'(MAX_WAIT)) ? wait_q + 4'd1 : wait_q;
`endif
      end
      ISSUE: begin
        state_d = WAIT;
        lat_d   = 4'(MEM_LAT);
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d     = ACK;
          cpu_rdata_d = (!we_q && !own_q) ? mem_rdata : cpu_rdata_q;
          dma_rdata_d = (!we_q && own_q) ? mem_rdata : dma_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and registered outputs, derived from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      wait_q      <= '0;
      last_q      <= 1'b1;
      own_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      wait_q      <= wait_d;
      last_q      <= last_d;
      own_q       <= own_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      mem_en_q    <= state_d == ISSUE;
      mem_we_q    <= (state_d == ISSUE) & we_d;
      cpu_ack_q   <= (state_d == ACK) & ~own_d;
      dma_ack_q   <= (state_d == ACK) & own_d;
      busy_q      <= state_d != IDLE;
    end
  end
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign arb_busy  = busy_q;
  assign arb_owner = own_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized CPU/DMA traffic against a transaction-level arbitration and timing model
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int LAT = 3;
  localparam int MW  = 2;
  logic        clk = 0, rst = 1;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_ack, cpu_stall, dma_ack, mem_en, mem_we, arb_busy, arb_owner;
  int          passed = 0, total = 0, cyc = 0, rcnt = 0;
  logic [3:0]  ridx = 0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  bit          cpu_pend, dma_pend, granted, g_own, g_we, last, e_owner;
  int          next_dec, g_cyc, wcnt;
  logic [31:0] g_addr, g_wdata, g_rd, e_crd, e_drd;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .arb_busy(arb_busy), .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro: read data valid only in the LAT-th cycle after the strobe, garbage otherwise
  always @(posedge clk) begin
    if (rcnt > 0) rcnt--;
    if (mem_en && mem_we) mem[mem_addr[5:2]] = mem_wdata;
    if (mem_en && !mem_we) begin
      rcnt = LAT;
      ridx = mem_addr[5:2];
    end
    #1 mem_rdata = (rcnt == 1) ? mem[ridx] : $urandom;
  end

  task automatic model_reset();
    granted = 0; next_dec = 0; wcnt = 0; last = 1; e_owner = 0;
    e_crd = 0; e_drd = 0; cpu_pend = 0; dma_pend = 0; cpu_req = 0; dma_req = 0;
  endtask

  task automatic start_cpu(bit we, logic [31:0] a, logic [31:0] d);
    cpu_pend = 1; cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic start_dma(bit we, logic [31:0] a, logic [31:0] d);
    dma_pend = 1; dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  // Drives both requesters and checks every cycle against the transaction model
  task automatic run(int ncyc, int pc, int pd);
    bit pca = 0, pda = 0, done = 0, w, ea_c, ea_d, e_en, e_busy;
    int c;
    for (int i = 0; i < ncyc + 300 && !done; i++) begin
      c = cyc;
      if (pca) cpu_pend = 0;
      if (pda) dma_pend = 0;
      if (!cpu_pend && i < ncyc && $urandom_range(99) < pc) start_cpu(1'($urandom_range(1)), $urandom, $urandom);
      if (!dma_pend && i < ncyc && $urandom_range(99) < pd) start_dma(1'($urandom_range(1)), $urandom, $urandom);
      cpu_req = cpu_pend;
      dma_req = dma_pend;
      #1;
      ea_c = granted && c == g_cyc + 2 + LAT && !g_own;
      total++; if (cpu_stall !== (cpu_req & ~ea_c)) $display("FAIL cpu_stall c=%0d got %b exp %b", c, cpu_stall, cpu_req & ~ea_c); else passed++;
      if (c >= next_dec) begin
        if (cpu_req || dma_req) begin
`ifdef ARB_RR_EN
          w = dma_req && (!cpu_req || !last);
`else
          w = dma_req && (!cpu_req || wcnt == MW);
          if (w) wcnt = 0;
          else if (dma_req && wcnt < MW) wcnt++;
`endif
          last = w; g_own = w; granted = 1; g_cyc = c; next_dec = c + 3 + LAT;
          g_we = w ? dma_we : cpu_we;
          g_addr = w ? dma_addr : cpu_addr;
          g_wdata = w ? dma_wdata : cpu_wdata;
          if (g_we) ref_mem[g_addr[5:2]] = g_wdata;
          else g_rd = ref_mem[g_addr[5:2]];
        end else if (i >= ncyc) done = 1;
      end
      if (!done) begin
        @(posedge clk); #1;
        c = cyc;
        e_en = granted && c == g_cyc + 1;
        ea_c = granted && c == g_cyc + 2 + LAT && !g_own;
        ea_d = granted && c == g_cyc + 2 + LAT && g_own;
        e_busy = granted && c > g_cyc && c <= g_cyc + 2 + LAT;
        if (e_en) e_owner = g_own;
        if (ea_c && !g_we) e_crd = g_rd;
        if (ea_d && !g_we) e_drd = g_rd;
        total++; if (mem_en !== e_en) $display("FAIL mem_en c=%0d got %b exp %b", c, mem_en, e_en); else passed++;
        total++; if (mem_we !== (e_en & g_we)) $display("FAIL mem_we c=%0d got %b exp %b", c, mem_we, e_en & g_we); else passed++;
        if (e_en) begin
          total++; if (mem_addr !== g_addr) $display("FAIL mem_addr c=%0d got %h exp %h", c, mem_addr, g_addr); else passed++;
          total++; if (mem_wdata !== g_wdata) $display("FAIL mem_wdata c=%0d got %h exp %h", c, mem_wdata, g_wdata); else passed++;
        end
        total++; if (cpu_ack !== ea_c) $display("FAIL cpu_ack c=%0d got %b exp %b", c, cpu_ack, ea_c); else passed++;
        total++; if (dma_ack !== ea_d) $display("FAIL dma_ack c=%0d got %b exp %b", c, dma_ack, ea_d); else passed++;
        total++; if (arb_busy !== e_busy) $display("FAIL arb_busy c=%0d got %b exp %b", c, arb_busy, e_busy); else passed++;
        total++; if (arb_owner !== e_owner) $display("FAIL arb_owner c=%0d got %b exp %b", c, arb_owner, e_owner); else passed++;
        total++; if (cpu_rdata !== e_crd) $display("FAIL cpu_rdata c=%0d got %h exp %h", c, cpu_rdata, e_crd); else passed++;
        total++; if (dma_rdata !== e_drd) $display("FAIL dma_rdata c=%0d got %h exp %h", c, dma_rdata, e_drd); else passed++;
        pca = cpu_ack;
        pda = dma_ack;
      end
    end
    total++; if (!done) $display("FAIL run_timeout got busy exp idle at c=%0d", cyc); else passed++;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({mem_en, mem_we, cpu_ack, dma_ack, arb_busy, arb_owner, cpu_stall} !== 7'b0)
      $display("FAIL reset_ctrl got %b exp 0", {mem_en, mem_we, cpu_ack, dma_ack, arb_busy, arb_owner, cpu_stall}); else passed++;
    total++; if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 128'b0)
      $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata}); else passed++;
    rst = 0;
    model_reset();
  endtask

  task automatic test_cpu_read();
    mem[0] = 32'h1234_5678;
    ref_mem[0] = 32'h1234_5678;
    start_cpu(0, 32'h0000_0040, $urandom);
    run(0, 0, 0);
    total++; if (cpu_rdata !== 32'h1234_5678) $display("FAIL cpu_read_data got %h exp 12345678", cpu_rdata); else passed++;
  endtask

  task automatic test_dma_write();
    start_dma(1, 32'h0000_0100, 32'hDEAD_BEEF);
    run(0, 0, 0);
    total++; if (mem[0] !== 32'hDEAD_BEEF) $display("FAIL dma_write_mem got %h exp deadbeef", mem[0]); else passed++;
  endtask

  task automatic test_back_to_back();
    run(60, 100, 0);
  endtask

  task automatic test_contention();
    run(80, 100, 100);
  endtask

  task automatic test_random();
    run(500, 30, 30);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    start_dma(0, $urandom, 0);
    for (int i = 0; i < 6 && !seen; i++) begin
      @(posedge clk); #1;
      seen = mem_en;
    end
    total++; if (!seen) $display("FAIL mid_issue got no mem_en exp mem_en"); else passed++;
    @(posedge clk); #2;
    rst = 1;
    #1;
    total++; if ({mem_en, mem_we, cpu_ack, dma_ack, arb_busy, arb_owner, cpu_stall} !== 7'b0)
      $display("FAIL mid_reset_ctrl got %b exp 0", {mem_en, mem_we, cpu_ack, dma_ack, arb_busy, arb_owner, cpu_stall}); else passed++;
    total++; if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 128'b0)
      $display("FAIL mid_reset_data got %h exp 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata}); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if ({dma_ack, arb_busy} !== 2'b0) $display("FAIL mid_reset_hold got %b exp 00", {dma_ack, arb_busy}); else passed++;
    end
    rst = 0;
    model_reset();
    start_cpu(0, $urandom, $urandom);
    run(0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_back_to_back();
    test_contention();
    test_random();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
